// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU codes, FSM states and decode record for the accumulator control unit.
// Build option: define CTRL_TRAP_EN to trap illegal opcodes into HALT with err raised.
package ctrl_pkg;
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_MUL4  = 4'h5;
  localparam logic [OPC_W-1:0] OP_DIV2  = 4'h6;
  localparam logic [OPC_W-1:0] OP_CLR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h8;
  localparam logic [OPC_W-1:0] OP_JMPZ  = 4'h9;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

`ifdef CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_PASS = 3'd2,
    ALU_ZER  = 3'd3,
    ALU_MUL4 = 3'd5,
    ALU_DIV2 = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_MEMWR, S_EXEC, S_HALT
  } state_e;

  // Where DECODE goes next; CLS_FETCH covers NOP, jumps and illegal opcodes.
  typedef enum logic [1:0] {CLS_FETCH, CLS_MEM, CLS_EXEC, CLS_HALT} cls_e;

  typedef struct packed {
    cls_e    cls;
    alu_op_e alu_op;
    logic    is_write;
    logic    is_jump;
    logic    is_cond;
    logic    is_illegal;
    logic    sets_z;
  } dec_t;
endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decode: next-state class, ALU op and control flags.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);
  always_comb begin
    dec = '{cls: CLS_FETCH, alu_op: ALU_ZER, is_write: 1'b0, is_jump: 1'b0,
            is_cond: 1'b0, is_illegal: 1'b0, sets_z: 1'b0};
    case (opcode)
      OP_NOP:   ;
      OP_LOAD:  begin dec.cls = CLS_MEM; dec.alu_op = ALU_PASS; dec.sets_z = 1'b1; end
      OP_STORE: begin dec.cls = CLS_MEM; dec.is_write = 1'b1; end
      OP_ADD:   begin dec.cls = CLS_MEM; dec.alu_op = ALU_ADD; end
      OP_SUB:   begin dec.cls = CLS_MEM; dec.alu_op = ALU_SUB; dec.sets_z = 1'b1; end
      OP_MUL4:  begin dec.cls = CLS_EXEC; dec.alu_op = ALU_MUL4; end
      OP_DIV2:  begin dec.cls = CLS_EXEC; dec.alu_op = ALU_DIV2; end
      OP_CLR:   begin dec.cls = CLS_EXEC; dec.alu_op = ALU_ZER; end
      OP_JMP:   dec.is_jump = 1'b1;
      OP_JMPZ:  begin dec.is_jump = 1'b1; dec.is_cond = 1'b1; end
      OP_HALT:  dec.cls = CLS_HALT;
      default:  dec.is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator datapath (fetch/decode/mem/exec).
// CTRL_TRAP_EN (see ctrl_pkg) selects trap-to-HALT versus NOP for illegal opcodes.
module alu_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               instr_req,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic               instr_ack,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  output logic               mdr_we,
  output logic [2:0]         alu_op,
  output logic               acc_we,
  input  logic               flag_z,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               err
);
  state_e               state, state_n;
  logic [ADDR_W-1:0]    pc_n, pc_inc, target;
  logic [INSTR_W-1:0]   ir, ir_n;
  logic                 z_q, z_n, err_q, err_n;
  dec_t                 dec;

  ctrl_decoder u_dec (.opcode(ir[INSTR_W-1 -: OPC_W]), .dec(dec));

  assign pc_inc     = pc + ADDR_W'(1);
  assign target     = ir[ADDR_W-1:0];
  assign instr_addr = pc;
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);
  assign err        = err_q;

  // Request strobes come straight from flops loaded with the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      z_q       <= 1'b0;
      err_q     <= 1'b0;
      instr_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      z_q       <= z_n;
      err_q     <= err_n;
      instr_req <= (state_n == S_FETCH);
      mem_req   <= (state_n == S_MEMRD) || (state_n == S_MEMWR);
      mem_we    <= (state_n == S_MEMWR);
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    z_n      = z_q;
    err_n    = err_q;
    mem_addr = '0;
    mdr_we   = 1'b0;
    acc_we   = 1'b0;
    alu_op   = ALU_ZER;
    case (state)
      S_IDLE, S_HALT: if (start) begin
        state_n = S_FETCH;
        pc_n    = '0;
        z_n     = 1'b0;
        err_n   = 1'b0;
      end
      S_FETCH: if (instr_ack) begin
        ir_n    = instr_data;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
        if (dec.is_illegal && TRAP_EN) begin
          // pc stays on the offending instruction for the trap handler
          state_n = S_HALT;
          pc_n    = pc;
          err_n   = 1'b1;
        end else begin
          case (dec.cls)
            CLS_MEM:  begin state_n = dec.is_write ? S_MEMWR : S_MEMRD; pc_n = pc; end
            CLS_EXEC: begin state_n = S_EXEC; pc_n = pc; end
            CLS_HALT: begin state_n = S_HALT; pc_n = pc; end
            default:  if (dec.is_jump && (!dec.is_cond || z_q)) pc_n = target;
          endcase
        end
      end
      S_MEMRD: begin
        mem_addr = target;
        if (mem_ack) begin
          mdr_we  = 1'b1;
          state_n = S_EXEC;
        end
      end
      S_MEMWR: begin
        mem_addr = target;
        if (mem_ack) begin
          pc_n    = pc_inc;
          state_n = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op  = dec.alu_op;
        acc_we  = 1'b1;
        pc_n    = pc_inc;
        state_n = S_FETCH;
        if (dec.sets_z) z_n = flag_z;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: doc/alu_ctrl_unit.md
Name: alu_ctrl_unit

Overview:
Multi-cycle control unit that sequences the 16-bit accumulator datapath around the shared ALU. It fetches 16-bit instructions over a req/ack handshake and decodes them. It drives the ALU op code, data-memory handshakes, accumulator/MDR write enables and the program counter. It captures the ALU zero flag for conditional jumps.

Parameters:
ADDR_W, 12, width of PC, instruction address and data-memory address
INSTR_W, 16, instruction width; opcode in [15:12], address/target in [ADDR_W-1:0]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE/HALT and begin execution at PC=0
instr_req  out  1  instruction fetch request, held until instr_ack
instr_addr  out  ADDR_W  fetch address (= pc)
instr_ack  in  1  instr_data valid this cycle
instr_data  in  INSTR_W  fetched instruction
mem_req  out  1  data-memory request, held until mem_ack
mem_we  out  1  1 = write accumulator to mem_addr, 0 = read
mem_addr  out  ADDR_W  data-memory address (instruction operand)
mem_ack  in  1  data-memory transfer complete
mdr_we  out  1  one-cycle pulse: datapath latches read data into MDR (B bus source)
alu_op  out  3  ALU operation: ADD=0, SUB=1, PASS=2, ZER=3, MUL4=5, DIV2=6
acc_we  out  1  one-cycle pulse: accumulator loads ALU result (C bus)
flag_z  in  1  ALU zero flag
pc  out  ADDR_W  program counter
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
err  out  1  illegal-opcode trap (CTRL_TRAP_EN only; else tied 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0; z_q=0; ir=0. All outputs 0 except alu_op=ZER.
- Opcodes: 0 NOP, 1 LOAD a, 2 STORE a, 3 ADD a, 4 SUB a, 5 MUL4, 6 DIV2, 7 CLR, 8 JMP a, 9 JMPZ a, F HALT; A-E illegal.
- States: IDLE, FETCH, DECODE, MEMRD, MEMWR, EXEC, HALT.
- IDLE/HALT --start--> FETCH. pc:=0, z_q:=0, err:=0. start is ignored while busy.
- FETCH: instr_req=1, instr_addr=pc. On instr_ack: ir:=instr_data, go to DECODE. No timeout.
- DECODE (1 cycle):
  - LOAD/ADD/SUB -> MEMRD; STORE -> MEMWR.
  - MUL4/DIV2/CLR -> EXEC.
  - NOP -> FETCH, pc+1.
  - JMP -> FETCH, pc:=a.
  - JMPZ -> FETCH, pc:=a if z_q else pc+1.
  - HALT -> HALT, pc unchanged.
- MEMRD: mem_req=1, mem_we=0, mem_addr=a. On mem_ack: mdr_we pulses in the same cycle, go to EXEC.
- MEMWR: mem_req=1, mem_we=1. On mem_ack: pc+1, go to FETCH. No ALU activity.
- EXEC (1 cycle): alu_op = PASS (LOAD), ADD, SUB, MUL4, DIV2 or ZER (CLR); acc_we=1; pc+1; go to FETCH.
  - z_q:=flag_z on SUB and LOAD only; all other ops leave z_q unchanged.
- alu_op outside EXEC: ZER (stable, no spurious flags).
- Latency: ALU-only op = 3 cycles + fetch wait. Memory op = 4 cycles + both waits. Jump = 2 + fetch wait.
- pc is ADDR_W bits and wraps all-ones -> 0 on increment.
- req outputs are registered; ack arriving in the first req cycle is accepted. An ack while req=0 is ignored.
- rst_n low mid-transaction drops req immediately (async); no partial write enable survives.

Optional Feature:
CTRL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to HALT with err=1 and pc pointing at the offending instruction. err clears on start.
- Undefined: illegal opcodes execute as NOP (pc+1); err is constant 0.

Decomposition:
- Package ctrl_pkg: opcode constants, ALU op constants (ADD/SUB/PASS/ZER/MUL4/DIV2), state encoding.
- Sub-module ctrl_decoder: combinational ir -> {next-state class, alu_op, uses_mem, is_write, is_jump, is_illegal}.
- FSM, pc and z_q stay in alu_ctrl_unit.

Test Plan:
- Reset, start, instructions 0x1005 (LOAD 5, mem=0x0000), 0x9010 (JMPZ 0x010) -> alu_op=2 and acc_we pulse in EXEC; z_q=1; pc becomes 0x010.
- 0x3007 (ADD 7) with mem_ack delayed 4 cycles -> mem_req held 4 cycles; mdr_we pulses once; EXEC alu_op=0; pc+1.
- 0x4003 (SUB 3) with flag_z=0, then 0x9020 -> JMPZ not taken, pc advances by 1.
- 0x200A (STORE 0x00A) -> mem_we=1 and mem_addr=0x00A until ack; acc_we never asserted; pc+1.
- pc=0xFFF fetching 0x5000 (MUL4) -> alu_op=5; pc wraps to 0x000. Then 0xF000 -> halted=1, busy=0; start -> FETCH at pc=0.
- Opcode 0xB000: with CTRL_TRAP_EN -> HALT, err=1; without -> NOP, pc+1. Assert rst_n mid-MEMRD -> outputs at reset values in the same cycle.
